// File: rtl/spi_flash_loader.sv
// Streams a contiguous flash image using dual-output fast read and hands it out one byte
// at a time over a valid/ready handshake, with the byte offset alongside each byte.
//
//   state  | meaning
//   sIdle  | flash deselected, waiting for Start
//   sCmd   | shifting the read opcode out on MOSI
//   sAddr  | shifting the 24-bit flash address out on MOSI
//   sDummy | dummy cells, IO0 released to the flash
//   sData  | collecting bit pairs into bytes, handing bytes to the consumer
//   sDone  | one-cycle Done pulse, flash deselected
module spi_flash_loader #(
    parameter logic [7:0] CMD   = 8'h3B,
    parameter int         DUMMY = 8
) (
    input  logic        C25M,
    input  logic        RES,
    input  logic        Start,
    input  logic [23:0] BaseAddr,
    input  logic [15:0] Len,
    output logic        nFCS,
    output logic        FCK,
    output logic        MOSIout,
    output logic        MOSIOE,
    input  logic        MOSIin,
    input  logic        MISO,
    output logic [7:0]  LDData,
    output logic [15:0] LDAddr,
    output logic        LDValid,
    input  logic        LDReady,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {sIdle, sCmd, sAddr, sDummy, sData, sDone} stateType;

    localparam logic [7:0] DummyLast = 8'(DUMMY - 1);

    stateType    state;
    logic        ph;
    logic [7:0]  cellCnt;
    logic [30:0] txShift;
    logic [7:0]  rxShift;
    logic        shFull;
    logic [15:0] shRemain;
    logic [15:0] accRemain;

    logic [7:0]  rxNext;
    logic        accept;

    assign rxNext = {rxShift[5:0], MISO, MOSIin};
    assign accept = LDValid && LDReady;

    always_ff @(posedge C25M) begin
        if (RES) begin
            state     <= sIdle;
            ph        <= 1'b0;
            cellCnt   <= 8'd0;
            txShift   <= 31'd0;
            rxShift   <= 8'd0;
            shFull    <= 1'b0;
            shRemain  <= 16'd0;
            accRemain <= 16'd0;
            nFCS      <= 1'b1;
            FCK       <= 1'b0;
            MOSIout   <= 1'b0;
            MOSIOE    <= 1'b0;
            LDData    <= 8'd0;
            LDAddr    <= 16'd0;
            LDValid   <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                sIdle: begin
                    if (Start) begin
                        if (Len == 16'd0) begin
                            state <= sDone;
                            Done  <= 1'b1;
                        end else begin
                            state     <= sCmd;
                            nFCS      <= 1'b0;
                            MOSIOE    <= 1'b1;
                            MOSIout   <= CMD[7];
                            Busy      <= 1'b1;
                            txShift   <= {CMD[6:0], BaseAddr};
                            cellCnt   <= 8'd7;
                            shRemain  <= Len;
                            accRemain <= Len;
                            LDAddr    <= 16'd0;
                            ph        <= 1'b0;
                        end
                    end
                end

                sCmd, sAddr, sDummy: begin
                    ph  <= ~ph;
                    FCK <= ~ph;
                    // Each cell ends on the edge leaving Ph=1; the next MOSI bit goes out there.
                    if (ph) begin
                        if (cellCnt != 8'd0) begin
                            cellCnt <= cellCnt - 8'd1;
                            if (state != sDummy) begin
                                MOSIout <= txShift[30];
                                txShift <= {txShift[29:0], 1'b0};
                            end
                        end else if (state == sCmd) begin
                            state   <= sAddr;
                            cellCnt <= 8'd23;
                            MOSIout <= txShift[30];
                            txShift <= {txShift[29:0], 1'b0};
                        end else if (state == sAddr) begin
                            state   <= sDummy;
                            cellCnt <= DummyLast;
                            MOSIout <= 1'b0;
                            MOSIOE  <= 1'b0;
                        end else begin
                            state   <= sData;
                            cellCnt <= 8'd3;
                        end
                    end
                end

                sData: begin
                    if (accept) begin
                        LDValid   <= 1'b0;
                        LDAddr    <= LDAddr + 16'd1;
                        accRemain <= accRemain - 16'd1;
                    end
                    if (accept && accRemain == 16'd1) begin
                        state <= sDone;
                        nFCS  <= 1'b1;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        FCK   <= 1'b0;
                        ph    <= 1'b0;
                    end else if (shFull) begin
                        // Clock stays frozen until the parked byte reaches the output register.
                        if (!LDValid || accept) begin
                            LDData  <= rxShift;
                            LDValid <= 1'b1;
                            shFull  <= 1'b0;
                        end
                    end else if (ph) begin
                        ph      <= 1'b0;
                        FCK     <= 1'b0;
                        rxShift <= rxNext;
                        if (cellCnt == 8'd0) begin
                            cellCnt  <= 8'd3;
                            shRemain <= shRemain - 16'd1;
                            if (!LDValid || accept) begin
                                LDData  <= rxNext;
                                LDValid <= 1'b1;
                            end else begin
                                shFull <= 1'b1;
                            end
                        end else begin
                            cellCnt <= cellCnt - 8'd1;
                        end
                    end else if (shRemain != 16'd0) begin
                        ph  <= 1'b1;
                        FCK <= 1'b1;
                    end
                end

                sDone: begin
                    state <= sIdle;
                end

                default: begin
                    state <= sIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: behavioural SPI flash, byte scoreboard, directed timing
// cases and randomized transfers with random consumer backpressure.
module tb_spi_flash_loader;

    localparam int DummyCells = 8;
    localparam int DataEdge0  = 32 + DummyCells;

    logic        C25M = 1'b0;
    logic        RES;
    logic        Start;
    logic [23:0] BaseAddr;
    logic [15:0] Len;
    logic        nFCS, FCK, MOSIout, MOSIOE;
    logic        misoDrv = 1'b0;
    logic        mosiInDrv = 1'b0;
    logic [7:0]  LDData;
    logic [15:0] LDAddr;
    logic        LDValid;
    logic        LDReady;
    logic        Busy, Done;

    spi_flash_loader dut (
        .C25M(C25M), .RES(RES), .Start(Start), .BaseAddr(BaseAddr), .Len(Len),
        .nFCS(nFCS), .FCK(FCK), .MOSIout(MOSIout), .MOSIOE(MOSIOE),
        .MOSIin(mosiInDrv), .MISO(misoDrv),
        .LDData(LDData), .LDAddr(LDAddr), .LDValid(LDValid), .LDReady(LDReady),
        .Busy(Busy), .Done(Done)
    );

    always #20 C25M = ~C25M;

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash contents: a fixed pattern at 0x004000, a scrambled function of the address elsewhere.
    function automatic logic [7:0] flashByte(input logic [23:0] a);
        case (a)
            24'h004000: return 8'hA5;
            24'h004001: return 8'h5A;
            24'h004002: return 8'h00;
            24'h004003: return 8'hFF;
            default:    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'hC3;
        endcase
    endfunction

    // ---------------- flash model ----------------
    int          edges = 0;
    int          lastEdges = 0;
    logic [31:0] capAddr = 32'd0;
    logic [31:0] lastCap = 32'd0;

    always @(posedge FCK or posedge nFCS) begin
        if (nFCS) begin
            lastEdges = edges;
            lastCap   = capAddr;
            edges     = 0;
        end else begin
            checkVal("mosiOE", MOSIOE, edges < 32);
            if (edges < 32) capAddr = {capAddr[30:0], MOSIout};
            edges++;
        end
    end

    always @(negedge FCK) begin : flashOut
        int p;
        int j;
        logic [7:0] bt;
        if (nFCS === 1'b0 && edges >= DataEdge0) begin
            p  = edges - DataEdge0;
            j  = p % 4;
            bt = flashByte(capAddr[23:0] + 24'(p / 4));
            misoDrv   = bt[7 - 2 * j];
            mosiInDrv = bt[6 - 2 * j];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    int          tStartG = 0;
    logic        resAtEdge = 1'b0;
    logic [23:0] expQ[$];
    int          newByteQ[$];
    int          fckQ[$];
    int          doneCount = 0, doneLabel = 0, nfcsRiseLabel = 0;
    int          acceptCnt = 0, busyCnt = 0, nfcsLowCnt = 0;
    logic        doneDue = 1'b0, zeroDue = 1'b0;
    logic        prevValid = 1'b0, prevReady = 1'b0, prevFck = 1'b0, prevNfcs = 1'b1;
    logic [7:0]  prevData = 8'd0;
    logic [15:0] prevAddr = 16'd0;

    always @(posedge C25M) begin
        cyc       <= cyc + 1;
        resAtEdge <= RES;
    end

    always @(negedge C25M) begin : monitor
        int label;
        logic expDone;
        logic [23:0] e;
        if (resAtEdge) begin
            checkVal("rstNfcs", nFCS, 1'b1);
            checkVal("rstFck", FCK, 1'b0);
            checkVal("rstMosi", MOSIout, 1'b0);
            checkVal("rstMosiOE", MOSIOE, 1'b0);
            checkVal("rstValid", LDValid, 1'b0);
            checkVal("rstData", LDData, 8'd0);
            checkVal("rstAddr", LDAddr, 16'd0);
            checkVal("rstBusy", Busy, 1'b0);
            checkVal("rstDone", Done, 1'b0);
            prevValid = 1'b0; prevReady = 1'b0; prevFck = 1'b0; prevNfcs = 1'b1;
            doneDue = 1'b0; zeroDue = 1'b0;
        end else begin
            label = cyc - tStartG + 1;
            if (FCK && !prevFck) fckQ.push_back(label);
            if (nFCS && !prevNfcs) nfcsRiseLabel = label;
            prevFck  = FCK;
            prevNfcs = nFCS;
            if (Busy) busyCnt++;
            if (!nFCS) nfcsLowCnt++;
            expDone = doneDue || zeroDue;
            if (Done || expDone) checkVal("donePulse", Done, expDone);
            if (Done) begin
                doneCount++;
                doneLabel = label;
            end
            doneDue = 1'b0;
            zeroDue = 1'b0;
            if (prevValid && !prevReady) begin
                checkVal("holdValid", LDValid, 1'b1);
                checkVal("holdData", LDData, prevData);
                checkVal("holdAddr", LDAddr, prevAddr);
            end
            if (LDValid && (!prevValid || prevReady)) newByteQ.push_back(label);
            if (LDValid && LDReady && !RES) begin
                acceptCnt++;
                if (expQ.size() == 0) begin
                    checkVal("extraByte", expQ.size(), 1);
                end else begin
                    e = expQ.pop_front();
                    checkVal("ldData", LDData, e[7:0]);
                    checkVal("ldAddr", LDAddr, e[23:8]);
                    if (expQ.size() == 0) doneDue = 1'b1;
                end
            end
            prevValid = LDValid;
            prevReady = LDReady && !RES;
            prevData  = LDData;
            prevAddr  = LDAddr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic runXfer(input logic [23:0] base, input logic [15:0] len, input bit randReady,
                           input int stallFrom, input int stallLen, input int injLabel,
                           input int abortAcc);
        int startDone, startAcc, lbl;
        bit aborted;
        @(negedge C25M);
        BaseAddr = base;
        Len      = len;
        Start    = 1'b1;
        tStartG  = cyc + 1;
        startDone = doneCount;
        startAcc  = acceptCnt;
        @(posedge C25M);
        #1;
        Start    = 1'b0;
        BaseAddr = 24'($urandom);
        Len      = 16'($urandom);
        newByteQ.delete();
        fckQ.delete();
        busyCnt    = 0;
        nfcsLowCnt = 0;
        for (int b = 0; b < int'(len); b++)
            expQ.push_back({16'(b), flashByte(base + 24'(b))});
        if (len == 16'd0) zeroDue = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (doneCount != startDone || aborted) break;
            lbl = cyc - tStartG + 1;
            LDReady = randReady ? ($urandom_range(0, 3) != 0)
                                : !(lbl >= stallFrom && lbl < stallFrom + stallLen);
            Start = (injLabel != 0 && lbl == injLabel);
            if (injLabel != 0 && lbl == injLabel) BaseAddr = ~base;
            if (abortAcc != 0 && acceptCnt - startAcc >= abortAcc) begin
                RES = 1'b1;
                expQ.delete();
                aborted = 1'b1;
            end
            @(posedge C25M);
            #1;
        end
        Start = 1'b0;
        if (aborted) begin
            RES = 1'b0;
        end else begin
            checkVal("doneCount", doneCount - startDone, 1);
            if (len != 16'd0) begin
                checkVal("cmdByte", lastCap[31:24], 8'h3B);
                checkVal("flashAddr", lastCap[23:0], base);
                checkVal("fckCells", lastEdges, DataEdge0 + 4 * int'(len));
            end
        end
    endtask

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0, inWin;
        int bpTimes[4];
        RES = 1'b1; Start = 1'b1; BaseAddr = 24'd0; Len = 16'd5; LDReady = 1'b0;
        repeat (3) @(posedge C25M);
        @(negedge C25M);
        RES = 1'b0; Start = 1'b0;
        repeat (4) @(negedge C25M);
        checkVal("idleNfcs", nFCS, 1'b1);
        checkVal("idleBusy", Busy, 1'b0);

        // Basic read with a steady consumer.
        runXfer(24'h004000, 16'd4, 1'b0, 0, 0, 0, 0);
        checkVal("nBytes", newByteQ.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < newByteQ.size()) checkVal("byteTime", newByteQ[k], 89 + 8 * k);
        checkVal("doneLabel", doneLabel, 114);
        checkVal("nfcsRise", nfcsRiseLabel, 114);
        checkVal("busyCycles", busyCnt, 113);

        // Backpressure: consumer stalls 40 cycles on the first byte.
        runXfer(24'h004000, 16'd4, 1'b0, 89, 40, 0, 0);
        bpTimes = '{89, 130, 138, 146};
        checkVal("bpBytes", newByteQ.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < newByteQ.size()) checkVal("bpByteTime", newByteQ[k], bpTimes[k]);
        inWin = 0;
        foreach (fckQ[k]) if (fckQ[k] >= 97 && fckQ[k] <= 128) inWin++;
        checkVal("bpFckFrozen", inWin, 0);
        checkVal("bpDoneLabel", doneLabel, 147);

        // Zero-length request.
        runXfer(24'h0A0B0C, 16'd0, 1'b0, 0, 0, 0, 0);
        checkVal("len0Done", doneLabel, 1);
        checkVal("len0Busy", busyCnt, 0);
        checkVal("len0Nfcs", nfcsLowCnt, 0);

        // Start pulsed during the address phase must be ignored.
        runXfer(24'h123456, 16'd3, 1'b0, 0, 0, 20, 0);
        d0 = doneCount;
        repeat (10) @(posedge C25M);
        checkVal("ignStartDone", doneCount - d0, 0);

        // Reset while byte 2 is being shifted in, then a fresh one-byte transfer.
        runXfer(24'h004000, 16'd4, 1'b0, 0, 0, 0, 2);
        d0 = doneCount;
        repeat (10) @(posedge C25M);
        #1;
        checkVal("abortNoDone", doneCount - d0, 0);
        checkVal("abortNfcs", nFCS, 1'b1);
        runXfer(24'hABCDEF, 16'd1, 1'b0, 0, 0, 0, 0);

        // Randomized transfers with random consumer readiness.
        for (int n = 0; n < 8; n++) begin
            runXfer(24'($urandom), 16'($urandom_range(1, 10)), 1'b1, 0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge C25M);
        end
        checkVal("queueDrained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/spi_flash_loader.md
# spi_flash_loader

Streams a contiguous image out of the card's SPI flash using dual-output fast read (0x3B) and hands it, one byte at a time with a valid/ready handshake, to the SDRAM write path. It sits upstream of the SDRAM command/data stage and replaces the inline per-state MOSI/MISO shifting used during the init load. It owns the flash pins (nFCS, FCK, MOSI) while busy. It tracks the byte offset so the consumer can form the SDRAM column/row address.

## Interface
Parameters:
- CMD, 8'h3B, flash read opcode (dual-output fast read)
- DUMMY, 8, dummy FCK cycles between address and data

Ports:
- C25M  in  1  system clock, 25 MHz
- RES  in  1  synchronous reset, active-high
- Start  in  1  one-cycle request; sampled only in IDLE
- BaseAddr  in  24  flash byte address, latched on accepted Start
- Len  in  16  byte count, latched on accepted Start; 0 = no transfer
- nFCS  out  1  flash chip select, active-low
- FCK  out  1  flash clock, C25M/2 when running, idles low
- MOSIout  out  1  value driven on MOSI/IO0
- MOSIOE  out  1  MOSI output enable; low releases IO0 for data
- MOSIin  in  1  IO0 pin readback (data bit 0 of each pair)
- MISO  in  1  IO1 (data bit 1 of each pair)
- LDData  out  8  byte to consumer
- LDAddr  out  16  offset of LDData from BaseAddr
- LDValid  out  1  LDData/LDAddr valid
- LDReady  in  1  consumer accepts when LDValid && LDReady
- Busy  out  1  high from accepted Start through Done
- Done  out  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- IDLE: nFCS=1, FCK=0, MOSIOE=0. Start && Len!=0 → CMD, with nFCS=0, MOSIOE=1 and Busy=1. Start && Len==0 → DONE directly; nFCS stays high.
- Bit cell = 2 C25M cycles, phase Ph. In Ph=0, FCK=0 and MOSIout is updated. In Ph=1, FCK=1. The flash samples on the FCK rising edge, which is SPI mode 0.
- CMD: shifts CMD MSB-first over 8 cells → ADDR.
- ADDR: shifts BaseAddr[23:0] MSB-first over 24 cells → DUMMY.
- DUMMY: MOSIOE=0 and MOSIout=0 for DUMMY cells → DATA.
- DATA: on the C25M edge that ends each Ph=1, the 8-bit shift register takes {shift[5:0], MISO, MOSIin}. 4 cells make one byte, MSB pair first.
- Buffering: one shift register plus one output register (LDData).
  - A completed byte moves to LDData when LDValid is low or is being accepted that cycle; LDValid then goes to 1.
  - Otherwise the byte is held as ShFull. FCK freezes low, with Ph held at 0, until the transfer happens.
- Accept (LDValid && LDReady):
  - LDAddr increments by one in 16 bits and wraps after FFFF; it starts at 0.
  - The remaining-byte counter decrements.
- No further FCK cells are issued once Len bytes have been shifted in.
- DATA → DONE when the last byte is accepted. In DONE: nFCS=1, Done=1 for one cycle, Busy=0, then IDLE.
- Start while Busy is ignored.
- The 24-bit flash address is not checked; flash-side wrap is the device's behaviour.

## Timing
- Reset: RES high at a C25M edge forces the state on the next cycle:
  - nFCS=1, FCK=0, MOSIout=0, MOSIOE=0
  - LDValid=0, LDData=0, LDAddr=0
  - Busy=0, Done=0, ShFull=0, state IDLE
  - Reset mid-transfer abandons the transfer without a Done pulse.
- Start accepted at edge T:
  - nFCS=0 from T+1.
  - First FCK rise at T+2.
  - With LDReady=1, byte k (0-based) has LDValid rise at T+1+2·(8+24+DUMMY+4)+8k, which is T+89+8k for DUMMY=8.
- LDValid stays high and LDData/LDAddr stay stable until accepted.
- Done pulses the cycle after the final accept. nFCS rises in that same cycle.
- Start is accepted in the first cycle back in IDLE, giving a minimum nFCS-high time of 2 cycles.
- A simultaneous accept and byte completion transfers without a stall.

## Test plan
- Reset: hold RES 3 cycles with Start=1 → nFCS=1, FCK=0, MOSIOE=0, LDValid=0, Busy=0, Done=0 throughout; no FCK edge.
- Basic read: BaseAddr=0x004000, Len=4, LDReady=1, flash model returns A5,5A,00,FF → the following, then Done at T+114 and nFCS high at T+114:
  - MOSI carries 0x3B, 0x00, 0x40, 0x00 MSB-first.
  - MOSIOE falls at DUMMY.
  - LDValid at T+89/97/105/113 with data A5/5A/00/FF and LDAddr 0/1/2/3.
- Backpressure: same setup, LDReady=0 from T+89 for 40 cycles:
  - byte 0 stays presented;
  - byte 1 completes into ShFull;
  - FCK holds low with no edges;
  - after release, all 4 bytes arrive in order, none lost or duplicated.
- Len=0: Start → Done at T+1, Busy never high, nFCS never low.
- Abort: RES asserted during DATA at byte 2 → next cycle all outputs at reset values, no Done. A new Start with Len=1 then completes normally, with LDAddr=0.
- Ignored start: pulse Start with different BaseAddr during ADDR → transfer continues with the original address and a single Done.
